mini_alu_core: RTL and testbench



---
 rtl/mini_alu_pkg.sv | 37 +++
 rtl/mini_alu_core_ret_addr_stack.sv | 58 +++++
 rtl/mini_alu_core.sv | 149 ++++++++++++++
 tb/tb_mini_alu_core.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_alu_pkg.sv
// mini_alu_pkg
//   Definitions shared by mini_alu_core and its testbench:
//   - the opcode encoding,
//   - the field indices of an instruction word,
//   - the bit positions inside the sticky fault vector.
//   Instruction word layout is {op[3:0], dest, src1, src0}. Each of dest, src1
//   and src0 is ADDR_W bits wide. Field k therefore starts at bit k*ADDR_W,
//   and the opcode sits above all three fields.
package mini_alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'd0,
    OP_STO  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_MUL  = 4'd4,
    OP_BLE  = 4'd5,
    OP_JMP  = 4'd6,
    OP_CALL = 4'd7,
    OP_RET  = 4'd8,
    OP_LED  = 4'd9,
    OP_OUT  = 4'd10
  } op_e;

  // Field indices; the bit offset of a field is index * ADDR_W.
  localparam int FLD_SRC0 = 0;
  localparam int FLD_SRC1 = 1;
  localparam int FLD_DEST = 2;
  localparam int FLD_OP   = 3;

  // Sticky fault bits.
  localparam int FAULT_STACK   = 0;  // return-stack overflow or underflow
  localparam int FAULT_ILLEGAL = 1;  // undefined opcode executed

endpackage

// File: rtl/mini_alu_core_ret_addr_stack.sv
// ret_addr_stack
//   LIFO of return addresses used by CALL/RET.
//   Ports:
//     Clock, Reset       : clock; synchronous active-high reset (reset empties the stack)
//     iPush, iPop        : push iData / pop the top entry; never asserted together
//     iData [WIDTH]      : address to push
//     oTop  [WIDTH]      : current top entry (0 when empty)
//     oFull, oEmpty      : occupancy flags
//   A push while full, or a pop while empty, is ignored here. The core
//   checks the flags itself and never issues such a request.
module ret_addr_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iPush,
  input  logic             iPop,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oTop,
  output logic             oFull,
  output logic             oEmpty
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign oFull  = (cnt_q == CW'(DEPTH));
  assign oEmpty = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (iPush && !oFull)       cnt_d = cnt_q + CW'(1);
    else if (iPop && !oEmpty)  cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge Clock) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Entry storage is left unreset; the count alone decides what is valid.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (iPush && !oFull && !Reset && (cnt_q == CW'(i))) mem_q[i] <= iData;
    end
  end

  always_comb begin
    oTop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) oTop = mem_q[i];
    end
  end

endmodule

// File: rtl/mini_alu_core.sv
// mini_alu_core
//   Two-stage fetch/execute core.
//   - Fetch loads IR from the external ROM.
//   - Execute decodes IR. It reads the register file combinationally, and
//     register writes commit on the same clock edge that loads the next IR.
//   Ports:
//     Clock, Reset            : clock; synchronous active-high reset
//     oIAddress   [PC_W]      : fetch address (the PC)
//     iInstruction[4+3*ADDR_W]: {op, dest, src1, src0}, valid combinationally for oIAddress
//     oLed        [LED_W]     : LED register
//     oOutData    [DATA_W]    : output-port payload
//     oOutValid, iOutReady    : output-port handshake
//     oFault      [2]         : sticky faults: [0] stack over/underflow, [1] illegal opcode
//   Output handshake:
//     oOutValid is high exactly while IR holds OUT and Reset is low.
//     A transfer happens on a posedge where oOutValid and iOutReady are both
//     high. Until that edge the whole core holds (PC, IR, registers, LED,
//     stack, faults), so oOutData stays stable.
module mini_alu_core
  import mini_alu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int PC_W     = 16,
  parameter int RS_DEPTH = 4,
  parameter int LED_W    = 8
) (
  input  logic                       Clock,
  input  logic                       Reset,
  output logic [PC_W-1:0]            oIAddress,
  input  logic [OP_W+3*ADDR_W-1:0]   iInstruction,
  output logic [LED_W-1:0]           oLed,
  output logic [DATA_W-1:0]          oOutData,
  output logic                       oOutValid,
  input  logic                       iOutReady,
  output logic [1:0]                 oFault
);

  localparam int IW = OP_W + 3 * ADDR_W;
  localparam logic [IW-1:0] IR_NOP = {OP_NOP, {(3 * ADDR_W){1'b0}}};

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [1:0]        fault_q, fault_d;
  logic [DATA_W-1:0] rf_q [2**ADDR_W];

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic              rs_push, rs_pop, rs_full, rs_empty;
  logic [PC_W-1:0]   rs_top;

  // Decode of the instruction currently held in IR.
  op_e               op;
  logic [ADDR_W-1:0] dest, src1, src0;
  logic [DATA_W-1:0] opa, opb, imm;
  logic [PC_W-1:0]   target;

  assign op     = op_e'(ir_q[FLD_OP*ADDR_W +: OP_W]);
  assign dest   = ir_q[FLD_DEST*ADDR_W +: ADDR_W];
  assign src1   = ir_q[FLD_SRC1*ADDR_W +: ADDR_W];
  assign src0   = ir_q[FLD_SRC0*ADDR_W +: ADDR_W];
  assign opa    = rf_q[src1];
  assign opb    = rf_q[src0];
  assign imm    = DATA_W'({src1, src0});
  assign target = PC_W'(dest);

  always_comb begin
    pc_d     = pc_q + PC_W'(1);  // wraps silently
    ir_d     = iInstruction;
    led_d    = led_q;
    fault_d  = fault_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    rs_push  = 1'b0;
    rs_pop   = 1'b0;
    case (op)
      OP_NOP: ;
      OP_STO: begin rf_we = 1'b1; rf_wdata = imm;       end
      OP_ADD: begin rf_we = 1'b1; rf_wdata = opa + opb; end
      OP_SUB: begin rf_we = 1'b1; rf_wdata = opa - opb; end
      OP_MUL: begin rf_we = 1'b1; rf_wdata = opa * opb; end
      OP_BLE: begin
        if (opa <= opb) begin pc_d = target; ir_d = IR_NOP; end
      end
      OP_JMP: begin pc_d = target; ir_d = IR_NOP; end
      OP_CALL: begin
        // PC has already advanced, so it is the return address.
        if (rs_full) fault_d[FAULT_STACK] = 1'b1;
        else begin rs_push = 1'b1; pc_d = target; ir_d = IR_NOP; end
      end
      OP_RET: begin
        if (rs_empty) fault_d[FAULT_STACK] = 1'b1;
        else begin rs_pop = 1'b1; pc_d = rs_top; ir_d = IR_NOP; end
      end
      OP_LED: led_d = opa[LED_W-1:0];
      OP_OUT: begin
        // Stall: refetch nothing and keep IR on the OUT.
        if (!iOutReady) begin pc_d = pc_q; ir_d = ir_q; end
      end
      default: fault_d[FAULT_ILLEGAL] = 1'b1;
    endcase
    if (Reset) begin
      rf_we   = 1'b0;
      rs_push = 1'b0;
      rs_pop  = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q    <= '0;
      ir_q    <= IR_NOP;
      led_q   <= '0;
      fault_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      led_q   <= led_d;
      fault_q <= fault_d;
    end
  end

  // Register file: no reset.
  always_ff @(posedge Clock) begin
    if (rf_we) rf_q[dest] <= rf_wdata;
  end

  ret_addr_stack #(
    .WIDTH (PC_W),
    .DEPTH (RS_DEPTH)
  ) u_ras (
    .Clock  (Clock),
    .Reset  (Reset),
    .iPush  (rs_push),
    .iPop   (rs_pop),
    .iData  (pc_q),
    .oTop   (rs_top),
    .oFull  (rs_full),
    .oEmpty (rs_empty)
  );

  assign oIAddress = pc_q;
  assign oLed      = led_q;
  assign oFault    = fault_q;
  assign oOutData  = opa;
  assign oOutValid = (op == OP_OUT) && !Reset;

endmodule

// File: tb/tb_mini_alu_core.sv
module tb_mini_alu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;
  logic [15:0] iaddr;
  logic [27:0] instr;
  logic [7:0]  led;
  logic [15:0] out_data;
  logic        out_valid;
  logic [1:0]  fault;

  logic [27:0] rom [256];
  logic [15:0] exp_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          xfer_cnt   = 0;
  logic [15:0] tr [16];

  assign instr = rom[iaddr[7:0]];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  mini_alu_core dut (
    .Clock        (clk),
    .Reset        (rst),
    .oIAddress    (iaddr),
    .iInstruction (instr),
    .oLed         (led),
    .oOutData     (out_data),
    .oOutValid    (out_valid),
    .iOutReady    (out_ready),
    .oFault       (fault)
  );

  // ---------------- encoding helpers ----------------
  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [27:0] sto(input logic [7:0] r, input logic [15:0] v);
    return {4'd1, r, v[15:8], v[7:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic enter_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) rom[i] = 28'h0;
  endtask

  task automatic leave_reset();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic trace(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tr[k] = iaddr;
    end
  endtask

  task automatic wait_valid(input string name);
    int seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    check({name, "_valid_seen"}, seen, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL out_unexpected actual=%h expected=none", out_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        compared++;
        if (out_data !== e) begin
          mismatched++;
          $display("FAIL out_data actual=%h expected=%h", out_data, e);
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    int x0;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 28'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pc", iaddr, 0);
    check("rst_led", led, 0);
    check("rst_fault", fault, 0);
    check("rst_valid", out_valid, 0);

    // SUB then OUT: 5 - 3 = 2
    enter_reset();
    rom[0] = sto(8'd1, 16'h0005);
    rom[1] = sto(8'd2, 16'h0003);
    rom[2] = ins(4'd3, 8'd3, 8'd1, 8'd2);
    rom[3] = ins(4'd10, 8'd0, 8'd3, 8'd0);
    rom[4] = ins(4'd6, 8'd4, 8'd0, 8'd0);
    exp_q.push_back(16'h0002);
    x0 = xfer_cnt;
    leave_reset();
    drain("sub");
    check("sub_xfers", xfer_cnt - x0, 1);
    check("sub_led", led, 0);
    check("sub_fault", fault, 0);

    // Modulo ADD and MUL, back-to-back OUTs
    enter_reset();
    rom[0] = sto(8'd1, 16'hFFFF);
    rom[1] = sto(8'd2, 16'h0001);
    rom[2] = ins(4'd2, 8'd4, 8'd1, 8'd2);
    rom[3] = sto(8'd6, 16'h0100);
    rom[4] = ins(4'd4, 8'd5, 8'd6, 8'd6);
    rom[5] = ins(4'd10, 8'd0, 8'd4, 8'd0);
    rom[6] = ins(4'd10, 8'd0, 8'd5, 8'd0);
    rom[7] = sto(8'd7, 16'h1357);
    rom[8] = ins(4'd10, 8'd0, 8'd7, 8'd0);
    rom[9] = ins(4'd6, 8'd9, 8'd0, 8'd0);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h1357);
    x0 = xfer_cnt;
    leave_reset();
    drain("modulo");
    check("modulo_xfers", xfer_cnt - x0, 3);

    // BLE taken (3 <= 3): one bubble, then 0x20
    enter_reset();
    rom[0]    = sto(8'd1, 16'h0003);
    rom[1]    = sto(8'd2, 16'h0003);
    rom[2]    = ins(4'd5, 8'h20, 8'd1, 8'd2);
    rom[3]    = sto(8'd7, 16'h0BAD);
    rom[4]    = ins(4'd10, 8'd0, 8'd7, 8'd0);
    rom[5]    = ins(4'd6, 8'd5, 8'd0, 8'd0);
    rom[8'h20] = sto(8'd8, 16'h0020);
    rom[8'h21] = ins(4'd10, 8'd0, 8'd8, 8'd0);
    rom[8'h22] = ins(4'd6, 8'h22, 8'd0, 8'd0);
    exp_q.push_back(16'h0020);
    leave_reset();
    trace(6);
    check("ble_t_pc3", tr[3], 16'h0003);
    check("ble_t_pc4", tr[4], 16'h0020);
    check("ble_t_pc5", tr[5], 16'h0021);
    drain("ble_taken");

    // BLE not taken (4 > 3): no bubble
    enter_reset();
    rom[0]    = sto(8'd1, 16'h0004);
    rom[1]    = sto(8'd2, 16'h0003);
    rom[2]    = ins(4'd5, 8'h20, 8'd1, 8'd2);
    rom[3]    = sto(8'd7, 16'h0BAD);
    rom[4]    = ins(4'd10, 8'd0, 8'd7, 8'd0);
    rom[5]    = ins(4'd6, 8'd5, 8'd0, 8'd0);
    rom[8'h20] = sto(8'd8, 16'h0020);
    rom[8'h21] = ins(4'd10, 8'd0, 8'd8, 8'd0);
    exp_q.push_back(16'h0BAD);
    leave_reset();
    trace(6);
    check("ble_n_pc4", tr[4], 16'h0004);
    check("ble_n_pc5", tr[5], 16'h0005);
    drain("ble_not_taken");

    // CALL 0x40 from 0x10, LED, RET back to 0x11
    enter_reset();
    rom[0]     = sto(8'd1, 16'h00A5);
    rom[1]     = ins(4'd6, 8'h10, 8'd0, 8'd0);
    rom[8'h10] = ins(4'd7, 8'h40, 8'd0, 8'd0);
    rom[8'h11] = sto(8'd9, 16'h0011);
    rom[8'h12] = ins(4'd10, 8'd0, 8'd9, 8'd0);
    rom[8'h13] = ins(4'd6, 8'h13, 8'd0, 8'd0);
    rom[8'h40] = ins(4'd9, 8'd0, 8'd1, 8'd0);
    rom[8'h41] = ins(4'd8, 8'd0, 8'd0, 8'd0);
    exp_q.push_back(16'h0011);
    leave_reset();
    trace(10);
    check("call_pc5", tr[5], 16'h0040);
    check("call_pc8", tr[8], 16'h0011);
    check("call_pc9", tr[9], 16'h0012);
    drain("call");
    check("call_led", led, 8'hA5);
    check("call_fault", fault, 2'b00);

    // Five nested CALLs with depth 4: fifth is a NOP
    enter_reset();
    rom[0]     = ins(4'd7, 8'd1, 8'd0, 8'd0);
    rom[1]     = ins(4'd7, 8'd2, 8'd0, 8'd0);
    rom[2]     = ins(4'd7, 8'd3, 8'd0, 8'd0);
    rom[3]     = ins(4'd7, 8'd4, 8'd0, 8'd0);
    rom[4]     = ins(4'd7, 8'h30, 8'd0, 8'd0);
    rom[5]     = sto(8'd10, 16'h0055);
    rom[6]     = ins(4'd10, 8'd0, 8'd10, 8'd0);
    rom[7]     = ins(4'd6, 8'd7, 8'd0, 8'd0);
    rom[8'h30] = sto(8'd10, 16'h0BAD);
    rom[8'h31] = ins(4'd10, 8'd0, 8'd10, 8'd0);
    rom[8'h32] = ins(4'd6, 8'h32, 8'd0, 8'd0);
    exp_q.push_back(16'h0055);
    leave_reset();
    drain("nest");
    check("nest_fault", fault, 2'b01);

    // RET on empty stack: NOP plus stack fault
    enter_reset();
    rom[0] = ins(4'd8, 8'd0, 8'd0, 8'd0);
    rom[1] = sto(8'd11, 16'h0077);
    rom[2] = ins(4'd10, 8'd0, 8'd11, 8'd0);
    rom[3] = ins(4'd6, 8'd3, 8'd0, 8'd0);
    exp_q.push_back(16'h0077);
    leave_reset();
    drain("underflow");
    check("underflow_fault", fault, 2'b01);

    // OUT stalled 5 cycles, then accepted
    enter_reset();
    rom[1] = ins(4'd10, 8'd0, 8'd3, 8'd0);
    rom[0] = sto(8'd3, 16'h1234);
    rom[2] = sto(8'd3, 16'h9999);
    rom[3] = ins(4'd10, 8'd0, 8'd3, 8'd0);
    rom[4] = ins(4'd6, 8'd4, 8'd0, 8'd0);
    out_ready = 1'b0;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h9999);
    x0 = xfer_cnt;
    leave_reset();
    wait_valid("stall");
    check("stall_c1_pc", iaddr, 16'h0002);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("stall_c%0d_valid", c), out_valid, 1);
      check($sformatf("stall_c%0d_pc", c), iaddr, 16'h0002);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("stall_c6_valid", out_valid, 1);
    check("stall_c6_pc", iaddr, 16'h0002);
    drain("stall");
    check("stall_xfers", xfer_cnt - x0, 2);

    // Reset in the middle of a stall: OUT abandoned
    enter_reset();
    rom[0] = sto(8'd3, 16'h1234);
    rom[1] = ins(4'd10, 8'd0, 8'd3, 8'd0);
    rom[2] = sto(8'd3, 16'h9999);
    rom[3] = ins(4'd10, 8'd0, 8'd3, 8'd0);
    rom[4] = ins(4'd6, 8'd4, 8'd0, 8'd0);
    out_ready = 1'b0;
    x0 = xfer_cnt;
    leave_reset();
    wait_valid("rststall");
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rststall_valid_low", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h9999);
    @(negedge clk);
    check("rststall_pc0", iaddr, 16'h0000);
    check("rststall_no_xfer", xfer_cnt - x0, 0);
    drain("rststall");

    // Illegal opcode 0xF: NOP plus sticky illegal fault
    enter_reset();
    rom[0] = ins(4'hF, 8'd12, 8'hAA, 8'hBB);
    rom[1] = sto(8'd12, 16'h0042);
    rom[2] = ins(4'd10, 8'd0, 8'd12, 8'd0);
    rom[3] = ins(4'd6, 8'd3, 8'd0, 8'd0);
    exp_q.push_back(16'h0042);
    leave_reset();
    drain("illegal");
    check("illegal_fault", fault, 2'b10);
    repeat (10) @(negedge clk);
    check("illegal_sticky", fault, 2'b10);
    enter_reset();
    @(negedge clk);
    check("illegal_cleared", fault, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
